// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM request queue: entry layout, issue FSM states, default widths.
package sdram_pkg;

  localparam int DEF_ADR_W = 27;
  localparam int DEF_DAT_W = 16;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_WR = 2'd2,
    WAIT_RD = 2'd3
  } state_t;

  typedef struct packed {
    logic                 write;
    logic [DEF_ADR_W-1:0] adr;
    logic [DEF_DAT_W-1:0] data;
  } entry_t;

  function automatic logic ctrl_idle(input logic init_done, input logic ctrl_busy);
    return init_done & ~ctrl_busy;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous FIFO for queued SDRAM commands; the tail entry can be rewritten in place
// so a write to the same address can merge into it.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int WIDTH = $bits(entry_t),
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   tail_wr,
  input  logic [WIDTH-1:0]       tail_wr_data,
  output logic [WIDTH-1:0]       head,
  output logic [WIDTH-1:0]       tail,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else if (tail_wr) begin
      mem_d[wr_ptr_q - PTR_ONE] = tail_wr_data;
    end else begin
      mem_d = mem_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      level_q  <= LVL_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign tail  = mem_q[wr_ptr_q - PTR_ONE];
  assign level = level_q;
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == LVL_ZERO);

endmodule

// File: rtl/sdram_req_queue.sv
// In-order command queue in front of sdram_controller; issues one command per controller idle.
// Optional feature macro: SDRAM_QUEUE_WRITE_MERGE_EN (same-address write merging into the tail entry).
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int ADR_W = DEF_ADR_W,
  parameter int DAT_W = DEF_DAT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADR_W-1:0]       cmd_adr,
  input  logic [DAT_W-1:0]       cmd_data,
  output logic                   rd_valid,
  output logic [DAT_W-1:0]       rd_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   sd_init_done,
  input  logic                   sd_busy,
  input  logic                   sd_data_valid,
  input  logic                   sd_write_done,
  input  logic [DAT_W-1:0]       sd_data_out,
  output logic                   sd_adv,
  output logic                   sd_rwn,
  output logic [ADR_W-1:0]       sd_addr,
  output logic [DAT_W-1:0]       sd_data_in
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_TWO = LW'(2);

`ifdef SDRAM_QUEUE_WRITE_MERGE_EN
  localparam logic MERGE_EN = 1'b1;
`else
  localparam logic MERGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic             write;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] data;
  } q_entry_t;

  q_entry_t      push_entry, head_entry, tail_entry;
  logic          push, pop, tail_wr, full, empty, merge_hit, accept;
  logic [LW-1:0] fifo_level;

  state_t           state_q, state_d;
  logic             sd_adv_q, sd_adv_d;
  logic             sd_rwn_q, sd_rwn_d;
  logic [ADR_W-1:0] sd_addr_q, sd_addr_d;
  logic [DAT_W-1:0] sd_data_in_q, sd_data_in_d;
  logic             rd_valid_q, rd_valid_d;
  logic [DAT_W-1:0] rd_data_q, rd_data_d;
  logic             busy_q, busy_d;

  sdram_req_fifo #(
    .WIDTH ($bits(q_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .push         (push),
    .push_data    (push_entry),
    .pop          (pop),
    .tail_wr      (tail_wr),
    .tail_wr_data (push_entry),
    .head         (head_entry),
    .tail         (tail_entry),
    .level        (fifo_level),
    .full         (full),
    .empty        (empty)
  );

  // level >= 2 keeps the merge target away from the head, which may be popping this cycle
  assign merge_hit  = MERGE_EN & cmd_valid & cmd_write & tail_entry.write &
                      (tail_entry.adr == cmd_adr) & (fifo_level >= LVL_TWO);
  assign cmd_ready  = ~full | merge_hit;
  assign accept     = cmd_valid & cmd_ready;
  assign push       = accept & ~merge_hit;
  assign tail_wr    = accept & merge_hit;
  assign push_entry = '{write: cmd_write, adr: cmd_adr, data: cmd_data};

  always_comb begin
    state_d      = state_q;
    sd_adv_d     = 1'b0;
    sd_rwn_d     = sd_rwn_q;
    sd_addr_d    = sd_addr_q;
    sd_data_in_d = sd_data_in_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && ctrl_idle(sd_init_done, sd_busy)) begin
          pop          = 1'b1;
          sd_adv_d     = 1'b1;
          sd_rwn_d     = head_entry.write;
          sd_addr_d    = head_entry.adr;
          sd_data_in_d = head_entry.data;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = sd_rwn_q ? WAIT_WR : WAIT_RD;
      WAIT_WR: begin
        if (sd_write_done) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_WR;
        end
      end
      WAIT_RD: begin
        if (sd_data_valid) begin
          rd_data_d  = sd_data_out;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT_RD;
        end
      end
      default: state_d = IDLE;
    endcase
    // a pop always moves the FSM out of IDLE, so non-empty-or-push covers the next queue state
    busy_d = (state_d != IDLE) | ~empty | push;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      sd_adv_q     <= 1'b0;
      sd_rwn_q     <= 1'b0;
      sd_addr_q    <= {ADR_W{1'b0}};
      sd_data_in_q <= {DAT_W{1'b0}};
      rd_valid_q   <= 1'b0;
      rd_data_q    <= {DAT_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sd_adv_q     <= sd_adv_d;
      sd_rwn_q     <= sd_rwn_d;
      sd_addr_q    <= sd_addr_d;
      sd_data_in_q <= sd_data_in_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
    end
  end

  assign sd_adv     = sd_adv_q;
  assign sd_rwn     = sd_rwn_q;
  assign sd_addr    = sd_addr_q;
  assign sd_data_in = sd_data_in_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign level      = fifo_level;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed testbench for sdram_req_queue with a small behavioural SDRAM controller model.
module tb_sdram_req_queue;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [26:0] cmd_adr = 27'h0;
  logic [15:0] cmd_data = 16'h0;
  logic        cmd_ready, rd_valid, busy, sd_adv, sd_rwn;
  logic [15:0] rd_data, sd_data_in;
  logic [3:0]  level;
  logic [26:0] sd_addr;
  logic        sd_init_done = 1'b1, hold_busy = 1'b0, inj_dv = 1'b0, inj_wd = 1'b0;
  logic [15:0] inj_data = 16'h0;
  logic        sd_busy, sd_data_valid, sd_write_done;
  logic [15:0] sd_data_out;

  logic        mdl_en = 1'b1, mdl_busy = 1'b0, mdl_dv = 1'b0, mdl_wd = 1'b0, mdl_wr = 1'b0;
  logic [15:0] mdl_dout = 16'h0, mdl_dat = 16'h0;
  logic [26:0] mdl_adr = 27'h0;
  int          mdl_cnt = 0;
  logic [15:0] mem [256];

  int vectors = 0, errors = 0;
  int cyc = 0, rd_cnt = 0, adv_double = 0, last_wd_cyc = 0;
  logic adv_prev = 1'b0;
  logic        lg_rwn [$];
  logic [26:0] lg_adr [$];
  logic [15:0] lg_dat [$];
  int          lg_cyc [$];

  assign sd_busy       = hold_busy | mdl_busy;
  assign sd_data_valid = mdl_dv | inj_dv;
  assign sd_write_done = mdl_wd | inj_wd;
  assign sd_data_out   = inj_dv ? inj_data : mdl_dout;

  sdram_req_queue dut (
    .i_clk(i_clk), .i_rst(i_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_adr(cmd_adr), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .level(level),
    .sd_init_done(sd_init_done), .sd_busy(sd_busy), .sd_data_valid(sd_data_valid),
    .sd_write_done(sd_write_done), .sd_data_out(sd_data_out), .sd_adv(sd_adv),
    .sd_rwn(sd_rwn), .sd_addr(sd_addr), .sd_data_in(sd_data_in)
  );

  always #5 i_clk = ~i_clk;

  // Controller model: accepts an issue, stays busy three cycles, then strobes completion.
  always @(posedge i_clk) begin
    mdl_wd <= 1'b0;
    mdl_dv <= 1'b0;
    if (i_rst) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= 0;
    end else if (mdl_busy) begin
      if (mdl_cnt == 1) begin
        mdl_busy <= 1'b0;
        if (mdl_wr) begin
          mem[mdl_adr[7:0]] <= mdl_dat;
          mdl_wd <= 1'b1;
        end else begin
          mdl_dout <= mem[mdl_adr[7:0]];
          mdl_dv   <= 1'b1;
        end
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end else if (mdl_en && sd_adv) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 3;
      mdl_wr   <= sd_rwn;
      mdl_adr  <= sd_addr;
      mdl_dat  <= sd_data_in;
    end
  end

  // Issue log and strobe counters
  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (sd_adv) begin
      lg_rwn.push_back(sd_rwn);
      lg_adr.push_back(sd_addr);
      lg_dat.push_back(sd_data_in);
      lg_cyc.push_back(cyc);
      if (adv_prev) adv_double <= adv_double + 1;
    end
    adv_prev <= sd_adv;
    if (rd_valid) rd_cnt <= rd_cnt + 1;
    if (sd_write_done) last_wd_cyc <= cyc;
  end

  task automatic push(input logic w, input logic [26:0] a, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_adr = a; cmd_data = d;
    @(negedge i_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_adv(input int budget);
    for (int i = 0; i < budget && sd_adv !== 1'b1; i++) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    vectors++; if ({cmd_ready, rd_valid, busy, sd_adv, sd_rwn} !== 5'b10000) begin errors++;
      $display("FAIL rst_flags: got %b expected 10000", {cmd_ready, rd_valid, busy, sd_adv, sd_rwn}); end
    vectors++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    vectors++; if ({rd_data, sd_data_in, sd_addr} !== 59'd0) begin errors++;
      $display("FAIL rst_data: got %h/%h/%h expected zeros", rd_data, sd_data_in, sd_addr); end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_single_write();
    bit ok;
    push(1'b1, 27'h0000123, 16'hBEEF);
    vectors++; if ({busy, sd_adv, level} !== {1'b1, 1'b0, 4'd1}) begin errors++;
      $display("FAIL sw_n1: got busy=%b adv=%b level=%0d expected 1 0 1", busy, sd_adv, level); end
    @(negedge i_clk);
    vectors++; if ({sd_adv, sd_rwn, sd_addr, sd_data_in} !== {1'b1, 1'b1, 27'h123, 16'hBEEF}) begin errors++;
      $display("FAIL sw_issue: got adv=%b rwn=%b addr=%h data=%h expected 1 1 123 beef", sd_adv, sd_rwn, sd_addr, sd_data_in); end
    vectors++; if (level !== 4'd0) begin errors++; $display("FAIL sw_level0: got %0d expected 0", level); end
    @(negedge i_clk);
    vectors++; if ({sd_adv, sd_addr} !== {1'b0, 27'h123}) begin errors++;
      $display("FAIL sw_adv_width: got adv=%b addr=%h expected 0 123", sd_adv, sd_addr); end
    for (int i = 0; i < 20 && sd_write_done !== 1'b1; i++) @(negedge i_clk);
    vectors++; if ({sd_write_done, busy} !== 2'b11) begin errors++;
      $display("FAIL sw_done: got wd=%b busy=%b expected 1 1", sd_write_done, busy); end
    @(negedge i_clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_fall: got %b expected 0", busy); end
    wait_idle(20, ok);
  endtask

  task automatic test_write_read();
    bit ok;
    int n0 = lg_adr.size();
    int r0 = rd_cnt;
    push(1'b1, 27'h40, 16'hA5A5);
    push(1'b0, 27'h40, 16'h0000);
    vectors++; if (level !== 4'd1) begin errors++; $display("FAIL wr_level: got %0d expected 1", level); end
    for (int i = 0; i < 40 && rd_valid !== 1'b1; i++) @(negedge i_clk);
    vectors++; if ({rd_valid, rd_data} !== {1'b1, 16'hA5A5}) begin errors++;
      $display("FAIL wr_rdata: got valid=%b data=%h expected 1 a5a5", rd_valid, rd_data); end
    repeat (3) @(negedge i_clk);
    vectors++; if ({rd_valid, rd_data} !== {1'b0, 16'hA5A5}) begin errors++;
      $display("FAIL wr_hold: got valid=%b data=%h expected 0 a5a5", rd_valid, rd_data); end
    vectors++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL wr_pulses: got %0d expected 1", rd_cnt - r0); end
    vectors++;
    if (lg_adr.size() != n0 + 2) begin errors++; $display("FAIL wr_issues: got %0d expected %0d", lg_adr.size(), n0 + 2); end
    else if (!(lg_rwn[n0] == 1'b1 && lg_rwn[n0+1] == 1'b0 && lg_adr[n0+1] == 27'h40 &&
               lg_cyc[n0] < last_wd_cyc && last_wd_cyc < lg_cyc[n0+1])) begin errors++;
      $display("FAIL wr_order: got read issue cycle %0d write done cycle %0d expected read after done", lg_cyc[n0+1], last_wd_cyc); end
    wait_idle(20, ok);
  endtask

  task automatic test_fill();
    bit ok;
    int n0 = lg_adr.size();
    hold_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = 27'h200 + 27'(i); cmd_data = 16'h1000 + 16'(i);
      #1;
      vectors++; if (cmd_ready !== (i < 8)) begin errors++; $display("FAIL fill_ready%0d: got %b expected %b", i, cmd_ready, i < 8); end
      @(negedge i_clk);
    end
    cmd_valid = 1'b0;
    vectors++; if ({level, cmd_ready} !== {4'd8, 1'b0}) begin errors++;
      $display("FAIL fill_full: got level=%0d ready=%b expected 8 0", level, cmd_ready); end
    hold_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      wait_adv(20);
      vectors++; if ({sd_adv, sd_addr, sd_data_in, level} !== {1'b1, 27'h200 + 27'(k), 16'h1000 + 16'(k), 4'(7 - k)}) begin errors++;
        $display("FAIL fill_drain%0d: got adv=%b addr=%h data=%h level=%0d expected 1 %h %h %0d",
                 k, sd_adv, sd_addr, sd_data_in, level, 27'h200 + 27'(k), 16'h1000 + 16'(k), 7 - k); end
    end
    wait_idle(40, ok);
    vectors++; if (!ok || lg_adr.size() != n0 + 8) begin errors++;
      $display("FAIL fill_count: got idle=%b issues=%0d expected 1 %0d", ok, lg_adr.size() - n0, 8); end
  endtask

  task automatic test_init_gate();
    bit ok;
    int a0 = lg_adr.size();
    sd_init_done = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b1, 27'h300 + 27'(i), 16'h2000 + 16'(i));
    repeat (5) @(negedge i_clk);
    vectors++; if (lg_adr.size() != a0 || level !== 4'd3) begin errors++;
      $display("FAIL init_gate: got issues=%0d level=%0d expected 0 3", lg_adr.size() - a0, level); end
    sd_init_done = 1'b1;
    @(negedge i_clk);
    vectors++; if ({sd_adv, sd_addr} !== {1'b1, 27'h300}) begin errors++;
      $display("FAIL init_release: got adv=%b addr=%h expected 1 300", sd_adv, sd_addr); end
    wait_idle(60, ok);
    vectors++; if (!ok || lg_adr.size() != a0 + 3 || lg_adr[a0+2] != 27'h302) begin errors++;
      $display("FAIL init_drain: got idle=%b issues=%0d expected 1 3", ok, lg_adr.size() - a0); end
  endtask

  task automatic test_strobe_ignore();
    bit ok;
    int r0 = rd_cnt;
    mdl_en = 1'b0;
    inj_dv = 1'b1; inj_wd = 1'b1; inj_data = 16'hDEAD;
    @(negedge i_clk);
    inj_dv = 1'b0; inj_wd = 1'b0;
    @(negedge i_clk);
    vectors++; if (rd_cnt != r0 || rd_data !== 16'hA5A5 || busy !== 1'b0) begin errors++;
      $display("FAIL ign_idle: got pulses=%0d data=%h busy=%b expected 0 a5a5 0", rd_cnt - r0, rd_data, busy); end
    push(1'b1, 27'h50, 16'h1111);
    wait_adv(10);
    repeat (2) @(negedge i_clk);
    inj_dv = 1'b1;
    @(negedge i_clk);
    inj_dv = 1'b0;
    @(negedge i_clk);
    vectors++; if (rd_cnt != r0 || rd_data !== 16'hA5A5 || busy !== 1'b1) begin errors++;
      $display("FAIL ign_wait_wr: got pulses=%0d data=%h busy=%b expected 0 a5a5 1", rd_cnt - r0, rd_data, busy); end
    inj_wd = 1'b1;
    @(negedge i_clk);
    inj_wd = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_wd_done: got busy=%b expected 0", busy); end
    wait_idle(5, ok);
    mdl_en = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    int r0 = rd_cnt;
    int a0;
    mdl_en = 1'b0;
    push(1'b0, 27'h77, 16'h0000);
    wait_adv(10);
    push(1'b1, 27'h78, 16'h3333);
    push(1'b1, 27'h79, 16'h4444);
    vectors++; if (level !== 4'd2) begin errors++; $display("FAIL rmr_level_pre: got %0d expected 2", level); end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    inj_dv = 1'b1; inj_data = 16'hCAFE;
    @(negedge i_clk);
    inj_dv = 1'b0;
    a0 = lg_adr.size();
    repeat (4) @(negedge i_clk);
    vectors++; if (rd_cnt != r0 || rd_data !== 16'h0000) begin errors++;
      $display("FAIL rmr_rd: got pulses=%0d data=%h expected 0 0000", rd_cnt - r0, rd_data); end
    vectors++; if ({level, busy, sd_adv, sd_addr} !== {4'd0, 1'b0, 1'b0, 27'h0} || lg_adr.size() != a0) begin errors++;
      $display("FAIL rmr_state: got level=%0d busy=%b adv=%b addr=%h expected 0 0 0 0", level, busy, sd_adv, sd_addr); end
    mdl_en = 1'b1;
  endtask

  task automatic test_merge();
    bit ok;
    int n0 = lg_adr.size();
`ifdef SDRAM_QUEUE_WRITE_MERGE_EN
    int exp_lvl = 2;
    logic [15:0] exp_second = 16'd3;
`else
    int exp_lvl = 3;
    logic [15:0] exp_second = 16'd2;
`endif
    hold_busy = 1'b1;
    push(1'b1, 27'h10, 16'd1);
    push(1'b1, 27'h20, 16'd2);
    push(1'b1, 27'h20, 16'd3);
    vectors++; if (level !== 4'(exp_lvl)) begin errors++; $display("FAIL mrg_level: got %0d expected %0d", level, exp_lvl); end
    hold_busy = 1'b0;
    wait_idle(60, ok);
    vectors++;
    if (!ok || lg_adr.size() != n0 + exp_lvl) begin errors++;
      $display("FAIL mrg_issues: got idle=%b issues=%0d expected 1 %0d", ok, lg_adr.size() - n0, exp_lvl); end
    else if (lg_adr[n0+1] != 27'h20 || lg_dat[n0+1] != exp_second || mem[8'h20] != 16'd3) begin errors++;
      $display("FAIL mrg_data: got addr=%h data=%h mem=%h expected 20 %h 0003", lg_adr[n0+1], lg_dat[n0+1], mem[8'h20], exp_second); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_single_write();
    test_write_read();
    test_fill();
    test_init_gate();
    test_strobe_ignore();
    test_reset_mid_read();
    test_merge();
    vectors++; if (adv_double != 0) begin errors++; $display("FAIL adv_one_cycle: got %0d double pulses expected 0", adv_double); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
